cp0_exception_unit: RTL and testbench
=====================================

CP0_EXCEPTION_UNIT -- requirements
Module: cp0_exception_unit

Interface
REQ-001 SHALL have parameter HANDLER_VECTOR, default 32'h0000_0180, the handler entry address.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port exception  input  1  exception detected this cycle.
REQ-005 SHALL have port cause  input  32  cause vector: bit0 illegal instruction, bit1 illegal ALU control, bit2 overflow; bits[31:3] ignored.
REQ-006 SHALL have port epc  input  32  address of the faulting instruction; valid only when exception=1.
REQ-007 SHALL have port eret  input  1  return-from-exception instruction issued.
REQ-008 SHALL have port cp0_we  input  1  move-to-CP0 write strobe.
REQ-009 SHALL have port cp0_addr  input  5  CP0 register select for both read and write.
REQ-010 SHALL have port cp0_wdata  input  32  move-to-CP0 write data.
REQ-011 SHALL have port cp0_rdata  output  32  combinational read of the selected register; 0 for unmapped addresses.
REQ-012 SHALL have port redirect_valid  output  1  PC redirect request.
REQ-013 SHALL have port redirect_target  output  32  redirect address; stable while redirect_valid=1.
REQ-014 SHALL have port redirect_ready  input  1  PC stage accepts redirect.
REQ-015 SHALL have port flush  output  1  one-cycle pipeline flush pulse.
REQ-016 SHALL have port in_handler  output  1  mirrors Status.EXL.

Function
REQ-017 SHALL implement registers Status (addr 12: bit1 EXL, other bits 0), Cause (addr 13: bits[2:0] cause code, bit31 nested flag, other bits 0) and EPC (addr 14).
REQ-018 SHALL implement an FSM with states IDLE, EXC_REDIR, HANDLER and RET_REDIR.
REQ-019 In IDLE with exception=1 at edge N, SHALL at edge N capture EPC<=epc, Cause[2:0]<=cause[2:0], Cause[31]<=0 and EXL<=1, then enter EXC_REDIR.
REQ-020 In EXC_REDIR SHALL drive redirect_valid=1 and redirect_target=HANDLER_VECTOR until a cycle with redirect_ready=1, then enter HANDLER.
REQ-021 flush SHALL pulse high for exactly the cycle following the capture edge (first EXC_REDIR cycle) and SHALL NOT pulse on the return path.
REQ-022 In HANDLER with eret=1, SHALL enter RET_REDIR and drive redirect_valid=1 with redirect_target=EPC (value at entry) until accepted.
REQ-023 On the accepting edge of RET_REDIR, SHALL clear EXL and enter IDLE.
REQ-024 exception=1 in any state other than IDLE SHALL set Cause[31] and leave EPC and Cause[2:0] unchanged.
REQ-025 exception and eret both high in HANDLER SHALL set Cause[31] and proceed with the return.
REQ-026 eret in IDLE, EXC_REDIR or RET_REDIR SHALL be ignored.
REQ-027 cp0_we SHALL write EPC, Status.EXL or Cause (bits 31 and [2:0]); a capture in the same cycle SHALL take priority over the write.
REQ-028 A cp0_we write to Status.EXL SHALL NOT change the FSM state.
REQ-029 redirect_valid SHALL be 0 in IDLE and HANDLER.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, EPC=0, Cause=0, Status=0, redirect_valid=0, flush=0 and redirect_target=0, independent of clk.
REQ-031 Reset asserted mid-redirect SHALL abort the redirect; no accept is required afterwards.

Configuration
REQ-032 With CP0_EXC_COUNT_EN defined, SHALL include a 32-bit counter at addr 9 that increments on each IDLE capture, wraps from FFFFFFFF to 0, resets to 0 and is writable via cp0_we.
REQ-033 Without CP0_EXC_COUNT_EN, the counter SHALL be absent and addr 9 SHALL read 0.

Verification
REQ-034 IDLE, exception=1, cause=4, epc=0x0040_0010 -> next cycle flush=1, redirect_valid=1, target=0x180, EPC=0x0040_0010, Cause=4, in_handler=1.
REQ-035 redirect_ready held 0 for 3 cycles -> valid and target held; ready=1 -> HANDLER entered, redirect_valid=0 the following cycle.
REQ-036 In HANDLER, eret=1 -> redirect_valid=1 with target=0x0040_0010 and flush=0; on accept -> in_handler=0, state IDLE.
REQ-037 exception=1, cause=1 while in EXC_REDIR -> Cause=0x8000_0004 and EPC unchanged.
REQ-038 In RET_REDIR, rst_n=0 -> all outputs 0 immediately; the next exception after release is captured normally.
REQ-039 With CP0_EXC_COUNT_EN, counter preset to FFFFFFFF via cp0_we, then one exception -> addr 9 reads 0.

Source files
------------

// File: rtl/cp0_exception_unit_if.sv
// ============================================================================
// Module : cp0_exception_unit_if
// Brief  : Exception-event, CP0 access and PC-redirect signals of the CP0 unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cp0_exception_unit_if;
    logic        exception;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_ready;
    logic        flush;
    logic        in_handler;

    modport master (
        output exception, cause, epc, eret, cp0_we, cp0_addr, cp0_wdata, redirect_ready,
        input  cp0_rdata, redirect_valid, redirect_target, flush, in_handler
    );

    modport slave (
        input  exception, cause, epc, eret, cp0_we, cp0_addr, cp0_wdata, redirect_ready,
        output cp0_rdata, redirect_valid, redirect_target, flush, in_handler
    );
endinterface

`default_nettype wire

// File: rtl/cp0_exception_unit.sv
// ============================================================================
// Module : cp0_exception_unit
// Brief  : CP0 Status/Cause/EPC registers with exception entry/return redirect.
//          Optional exception counter at CP0 addr 9 when CP0_EXC_COUNT_EN is set.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_exception_unit #(
    parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0180
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    cp0_exception_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EXC_REDIR = 2'd1,
        S_HANDLER   = 2'd2,
        S_RET_REDIR = 2'd3
    } state_t;

    localparam logic [4:0] C_ADDR_COUNT  = 5'd9;
    localparam logic [4:0] C_ADDR_STATUS = 5'd12;
    localparam logic [4:0] C_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] C_ADDR_EPC    = 5'd14;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_epc;
    logic [31:0] r_ret_target;
    logic [2:0]  r_cause_code;
    logic        r_cause_nest;
    logic        r_exl;
    logic        r_flush;

    logic        w_capture;
    logic        w_enter_ret;
    logic        w_ret_accept;
    logic        w_redirect_valid;
    logic [31:0] w_redirect_target;
    logic        w_nested;
    logic [31:0] w_rdata;
    logic        w_unused_cause_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_capture         = 1'b0;
        w_enter_ret       = 1'b0;
        w_ret_accept      = 1'b0;
        w_redirect_valid  = 1'b0;
        w_redirect_target = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (bus.exception) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_EXC_REDIR;
                end
            end
            S_EXC_REDIR: begin
                w_redirect_valid  = 1'b1;
                w_redirect_target = HANDLER_VECTOR;
                if (bus.redirect_ready) w_state_nxt = S_HANDLER;
            end
            S_HANDLER: begin
                if (bus.eret) begin
                    w_enter_ret = 1'b1;
                    w_state_nxt = S_RET_REDIR;
                end
            end
            S_RET_REDIR: begin
                w_redirect_valid  = 1'b1;
                w_redirect_target = r_ret_target;
                if (bus.redirect_ready) begin
                    w_ret_accept = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_nested = bus.exception && (r_state != S_IDLE);

    // Capture owns the registers outright; otherwise software writes apply first
    // and the nested flag / EXL clear on return override the written value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epc        <= 32'h0;
            r_cause_code <= 3'h0;
            r_cause_nest <= 1'b0;
            r_exl        <= 1'b0;
            r_flush      <= 1'b0;
            r_ret_target <= 32'h0;
        end else begin
            if (w_capture) begin
                r_epc        <= bus.epc;
                r_cause_code <= bus.cause[2:0];
                r_cause_nest <= 1'b0;
                r_exl        <= 1'b1;
            end else begin
                if (bus.cp0_we) begin
                    case (bus.cp0_addr)
                        C_ADDR_EPC:    r_epc <= bus.cp0_wdata;
                        C_ADDR_STATUS: r_exl <= bus.cp0_wdata[1];
                        C_ADDR_CAUSE: begin
                            r_cause_code <= bus.cp0_wdata[2:0];
                            r_cause_nest <= bus.cp0_wdata[31];
                        end
                        default: ;
                    endcase
                end
                if (w_nested)     r_cause_nest <= 1'b1;
                if (w_ret_accept) r_exl        <= 1'b0;
            end
            r_flush <= w_capture;
            if (w_enter_ret) r_ret_target <= r_epc;
        end
    end

`ifdef CP0_EXC_COUNT_EN
    logic [31:0] r_exc_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          r_exc_count <= 32'h0;
        else if (w_capture)                                  r_exc_count <= r_exc_count + 32'd1;
        else if (bus.cp0_we && (bus.cp0_addr == C_ADDR_COUNT)) r_exc_count <= bus.cp0_wdata;
    end
`endif

    always_comb begin
        w_rdata = 32'h0;
        case (bus.cp0_addr)
`ifdef CP0_EXC_COUNT_EN
            C_ADDR_COUNT:  w_rdata = r_exc_count;
`endif
            C_ADDR_STATUS: w_rdata = {30'h0, r_exl, 1'b0};
            C_ADDR_CAUSE:  w_rdata = {r_cause_nest, 28'h0, r_cause_code};
            C_ADDR_EPC:    w_rdata = r_epc;
            default:       w_rdata = 32'h0;
        endcase
    end

    assign w_unused_cause_bits = &{1'b0, bus.cause[31:3]};

    assign bus.cp0_rdata       = w_rdata;
    assign bus.redirect_valid  = w_redirect_valid;
    assign bus.redirect_target = w_redirect_target;
    assign bus.flush           = r_flush;
    assign bus.in_handler      = r_exl;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
// ============================================================================
// Module : tb_cp0_exception_unit
// Brief  : Directed stimulus with a redirect-target scoreboard for cp0_exception_unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_cp0_exception_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [31:0] exp_q[$];

    cp0_exception_unit_if bus ();

    cp0_exception_unit #(.HANDLER_VECTOR(32'h0000_0180)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", name, act, exp);
        end
    endtask

    task automatic chk_reg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        bus.cp0_addr = addr;
        #0.1;
        chk(name, bus.cp0_rdata, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted redirect must match the oldest expected target.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.redirect_valid && bus.redirect_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL redirect_unexpected: got=%08h want=none", bus.redirect_target);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.redirect_target !== e) begin
                        bad++;
                        $display("FAIL redirect_target: got=%08h want=%08h", bus.redirect_target, e);
                    end
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.exception      = 1'b0;
        bus.cause          = 32'h0;
        bus.epc            = 32'h0;
        bus.eret           = 1'b0;
        bus.cp0_we         = 1'b0;
        bus.cp0_addr       = 5'd0;
        bus.cp0_wdata      = 32'h0;
        bus.redirect_ready = 1'b0;

        #3;
        chk("rst_valid",   {31'h0, bus.redirect_valid}, 32'h0);
        chk("rst_target",  bus.redirect_target, 32'h0);
        chk("rst_flush",   {31'h0, bus.flush}, 32'h0);
        chk("rst_inh",     {31'h0, bus.in_handler}, 32'h0);
        chk_reg("rst_status", 5'd12, 32'h0);
        chk_reg("rst_cause",  5'd13, 32'h0);
        chk_reg("rst_epc",    5'd14, 32'h0);
        #4 rst_n = 1'b1;

        // Exception entry
        tick();
        bus.exception = 1'b1;
        bus.cause     = 32'hFFFF_FFFC;
        bus.epc       = 32'h0040_0010;
        exp_q.push_back(32'h0000_0180);
        tick();
        bus.exception = 1'b0;
        chk("e1_flush",  {31'h0, bus.flush}, 32'h1);
        chk("e1_valid",  {31'h0, bus.redirect_valid}, 32'h1);
        chk("e1_target", bus.redirect_target, 32'h0000_0180);
        chk("e1_inh",    {31'h0, bus.in_handler}, 32'h1);
        chk_reg("e1_epc",   5'd14, 32'h0040_0010);
        chk_reg("e1_cause", 5'd13, 32'h0000_0004);

        // Redirect stalled; nested exception during EXC_REDIR
        bus.exception = 1'b1;
        bus.cause     = 32'h1;
        bus.epc       = 32'h0000_9999;
        tick();
        bus.exception = 1'b0;
        chk("stall1_flush", {31'h0, bus.flush}, 32'h0);
        chk("stall1_valid", {31'h0, bus.redirect_valid}, 32'h1);
        chk_reg("nest_cause", 5'd13, 32'h8000_0004);
        chk_reg("nest_epc",   5'd14, 32'h0040_0010);
        tick();
        chk("stall2_valid",  {31'h0, bus.redirect_valid}, 32'h1);
        chk("stall2_target", bus.redirect_target, 32'h0000_0180);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        chk("eret_ign_target", bus.redirect_target, 32'h0000_0180);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        chk("hdl_valid", {31'h0, bus.redirect_valid}, 32'h0);
        chk("hdl_inh",   {31'h0, bus.in_handler}, 32'h1);

        // Return
        bus.eret = 1'b1;
        exp_q.push_back(32'h0040_0010);
        tick();
        bus.eret = 1'b0;
        chk("ret_valid",  {31'h0, bus.redirect_valid}, 32'h1);
        chk("ret_target", bus.redirect_target, 32'h0040_0010);
        chk("ret_flush",  {31'h0, bus.flush}, 32'h0);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        chk("idle_inh",   {31'h0, bus.in_handler}, 32'h0);
        chk("idle_valid", {31'h0, bus.redirect_valid}, 32'h0);
        chk_reg("idle_status", 5'd12, 32'h0);

        // Software writes
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h1234_5678;
        tick();
        bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0000_0002;
        tick();
        bus.cp0_we = 1'b0;
        chk_reg("wr_epc", 5'd14, 32'h1234_5678);
        chk("wr_exl_inh",   {31'h0, bus.in_handler}, 32'h1);
        chk("wr_exl_valid", {31'h0, bus.redirect_valid}, 32'h0);
        chk_reg("unmapped", 5'd5, 32'h0);
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'h0;
        tick();

        // Capture beats a simultaneous write
        bus.cp0_addr  = 5'd14; bus.cp0_wdata = 32'h0000_DEAD;
        bus.exception = 1'b1; bus.cause = 32'h2; bus.epc = 32'h0000_0100;
        exp_q.push_back(32'h0000_0180);
        tick();
        bus.cp0_we = 1'b0; bus.exception = 1'b0;
        chk_reg("prio_epc",   5'd14, 32'h0000_0100);
        chk_reg("prio_cause", 5'd13, 32'h0000_0002);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;

        // eret with exception in HANDLER
        bus.eret = 1'b1; bus.exception = 1'b1; bus.cause = 32'h4; bus.epc = 32'h0000_7777;
        exp_q.push_back(32'h0000_0100);
        tick();
        bus.eret = 1'b0; bus.exception = 1'b0;
        chk_reg("both_cause", 5'd13, 32'h8000_0002);
        chk("both_target", bus.redirect_target, 32'h0000_0100);

        // Reset during return redirect
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("arst_valid",  {31'h0, bus.redirect_valid}, 32'h0);
        chk("arst_target", bus.redirect_target, 32'h0);
        chk("arst_inh",    {31'h0, bus.in_handler}, 32'h0);
        chk_reg("arst_epc", 5'd14, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        chk("idle_eret_valid", {31'h0, bus.redirect_valid}, 32'h0);

`ifdef CP0_EXC_COUNT_EN
        bus.cp0_we = 1'b1; bus.cp0_addr = 5'd9; bus.cp0_wdata = 32'hFFFF_FFFF;
        tick();
        bus.cp0_we = 1'b0;
        chk_reg("cnt_preset", 5'd9, 32'hFFFF_FFFF);
`endif
        bus.exception = 1'b1; bus.cause = 32'h7; bus.epc = 32'h0000_2000;
        exp_q.push_back(32'h0000_0180);
        tick();
        bus.exception = 1'b0;
        chk("post_flush", {31'h0, bus.flush}, 32'h1);
        chk_reg("post_epc",   5'd14, 32'h0000_2000);
        chk_reg("post_cause", 5'd13, 32'h0000_0007);
        chk_reg("cnt_addr9",  5'd9,  32'h0);
        bus.redirect_ready = 1'b1;
        tick();
        bus.redirect_ready = 1'b0;
        tick();
        tick();
        chk("queue_empty", exp_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
